// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the MiniUart receive controller: register map,
// STATUS/CTRL bit layouts and drain FSM state codes.
package uart_rx_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_RS     = 0;
  localparam int ST_NEMPTY = 1;
  localparam int ST_FULL   = 2;
  localparam int ST_OVR    = 3;
  localparam int ST_BUSY   = 4;

  localparam int CTRL_RX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_CLEAR   = 2'd2,
    S_WAIT_LO = 2'd3
  } rx_state_t;

  // Packed MSB-first so the field order mirrors the register bit order.
  typedef struct packed {
    logic irq_en;
    logic rx_en;
  } ctrl_t;

  typedef struct packed {
    logic busy;
    logic overrun;
    logic full;
    logic nempty;
    logic rs;
  } status_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// CPU-side register bus of the receive controller, with the level interrupt.
interface uart_rx_ctrl_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output sel, we, addr, wdata, input rdata, irq);
  modport slave  (input sel, we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes; head is always visible, pop then push
// when both arrive on a full FIFO.
module uart_rx_fifo #(
  parameter int AW = 2,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         push_ok, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// MiniUart receive controller: 8x-baud sample tick, rs/over_read drain FSM,
// byte FIFO and CPU register block with level interrupt.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DIV_RST = 16'd27,
  parameter int               FIFO_AW = 2
) (
  input  logic           clk,
  input  logic           rst,
  output logic           en_rx,
  input  logic [7:0]     rx_data,
  input  logic           rx_rs,
  output logic           rx_over_read,
  uart_rx_ctrl_if.slave  bus
);

  logic [DIV_W-1:0] divisor, cnt;
  ctrl_t            ctrl;
  logic             rs_meta, rs_s;
  logic             overrun;
  rx_state_t        state, state_nxt;
  logic             capture;
  logic             push, pop, full, empty, ovr_set;
  logic [7:0]       head;
  logic             wr, rd, div_wr, ctrl_wr, stat_wr;
  status_t          status;
  logic             unused_wdata;

  assign wr      = bus.sel & bus.we;
  assign rd      = bus.sel & ~bus.we;
  assign div_wr  = wr && (bus.addr == ADDR_DIV);
  assign ctrl_wr = wr && (bus.addr == ADDR_CTRL);
  assign stat_wr = wr && (bus.addr == ADDR_STATUS);
  assign unused_wdata = ^bus.wdata;

  // ---------------- config registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor <= DIV_RST;
      ctrl    <= '0;
    end else begin
      if (div_wr)  divisor <= bus.wdata[DIV_W-1:0];
      if (ctrl_wr) ctrl    <= ctrl_t'(bus.wdata[1:0]);
    end
  end

  // ---------------- sample tick ----------------
  always_ff @(posedge clk) begin
    if (rst)              cnt <= DIV_RST;
    else if (div_wr)      cnt <= bus.wdata[DIV_W-1:0];
    else if (!ctrl.rx_en) cnt <= divisor;
    else if (cnt == '0)   cnt <= divisor;
    else                  cnt <= cnt - 1'b1;
  end

  assign en_rx = ctrl.rx_en & (cnt == '0);

  // rx_rs comes from the receive unit's derived clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_meta <= 1'b0;
      rs_s    <= 1'b0;
    end else begin
      rs_meta <= rx_rs;
      rs_s    <= rs_meta;
    end
  end

  // ---------------- drain FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    capture      = 1'b0;
    rx_over_read = 1'b0;
    case (state)
      S_IDLE:    if (rs_s) state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        capture   = 1'b1;
        state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        rx_over_read = 1'b1;
        state_nxt    = S_WAIT_LO;
      end
      // Wait for rs to fall so one byte is never captured twice.
      S_WAIT_LO: if (!rs_s) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FIFO ----------------
  assign pop     = rd && (bus.addr == ADDR_DATA) && !empty;
  assign push    = capture & (~full | pop);
  assign ovr_set = capture & full & ~pop;

  uart_rx_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (rx_data),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // A same-cycle overrun event takes priority over the software clear.
  always_ff @(posedge clk) begin
    if (rst)                              overrun <= 1'b0;
    else if (ovr_set)                     overrun <= 1'b1;
    else if (stat_wr && bus.wdata[ST_OVR]) overrun <= 1'b0;
  end

  // ---------------- read mux / irq ----------------
  always_comb begin
    status.busy    = (state != S_IDLE);
    status.overrun = overrun;
    status.full    = full;
    status.nempty  = ~empty;
    status.rs      = rs_s;
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_DATA:   bus.rdata = empty ? 32'd0 : {24'd0, head};
      ADDR_STATUS: bus.rdata = {27'd0, status};
      ADDR_DIV:    bus.rdata = 32'(divisor);
      ADDR_CTRL:   bus.rdata = {30'd0, ctrl};
      default:     bus.rdata = '0;
    endcase
  end

  assign bus.irq = ctrl.irq_en & (~empty | overrun);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a queue-based model of the byte FIFO and
// overrun flag, with a simple receive-unit model that clears rs on over_read.
module tb_uart_rx_ctrl;
  import uart_rx_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_rx, rx_over_read;
  logic       rx_rs = 1'b0;
  logic [7:0] rx_data = 8'd0;

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(.DIV_W(16), .DIV_RST(16'd27), .FIFO_AW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_rx        (en_rx),
    .rx_data      (rx_data),
    .rx_rs        (rx_rs),
    .rx_over_read (rx_over_read),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  byte unsigned model_q[$];
  bit          model_ovr = 1'b0;

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(logic [1:0] a, logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    step();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(logic [1:0] a, output logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1 d = bus.rdata;
    step();
    bus.sel = 1'b0;
  endtask

  task automatic peek(logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1 d = bus.rdata;
  endtask

  function automatic logic [31:0] exp_status();
    return {27'd0, 1'b0, model_ovr, (model_q.size() == DEPTH), (model_q.size() != 0), 1'b0};
  endfunction

  function automatic void model_rx(byte unsigned b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovr = 1'b1;
  endfunction

  task automatic wait_pulse(output int n);
    n = 0;
    do begin step(); n++; end while (!en_rx && n < 100);
    if (!en_rx) n = -1;
  endtask

  // Receive-unit model: raise rs with a byte, drop it hold cycles after over_read.
  task automatic send_byte(byte unsigned b, int hold);
    int pulses = 0;
    bit seen;
    rx_data = b; rx_rs = 1'b1;
    seen = rx_over_read;
    for (int i = 0; i < 30 && !seen; i++) begin step(); seen = rx_over_read; end
    if (seen) pulses++;
    repeat (hold) begin step(); if (rx_over_read) pulses++; end
    rx_rs = 1'b0;
    repeat (6) begin step(); if (rx_over_read) pulses++; end
    model_rx(b);
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL over_read_pulses: got %0d exp 1", pulses); end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int hits = 0;
    rst = 1'b1; step(3);
    checks++; if (en_rx !== 1'b0) begin errors++; $display("FAIL rst_en_rx: got %b exp 0", en_rx); end
    checks++; if (rx_over_read !== 1'b0) begin errors++; $display("FAIL rst_over_read: got %b exp 0", rx_over_read); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b exp 0", bus.irq); end
    peek(ADDR_STATUS, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_status: got %h exp 0", d); end
    peek(ADDR_DIV, d);
    checks++; if (d !== 32'd27) begin errors++; $display("FAIL rst_div: got %h exp 1b", d); end
    peek(ADDR_CTRL, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_ctrl: got %h exp 0", d); end
    peek(ADDR_DATA, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_data: got %h exp 0", d); end
    rst = 1'b0;
    repeat (40) begin step(); if (en_rx) hits++; end
    checks++; if (hits !== 0) begin errors++; $display("FAIL tick_disabled: got %0d pulses exp 0", hits); end
  endtask

  task automatic test_tick();
    int n, d, hi;
    bus_write(ADDR_DIV, 32'd3);
    bus_write(ADDR_CTRL, 32'd1);
    wait_pulse(n);
    checks++; if (n < 0) begin errors++; $display("FAIL tick_first: got timeout exp pulse"); end
    for (int i = 0; i < 3; i++) begin
      wait_pulse(n);
      checks++; if (n !== 4) begin errors++; $display("FAIL tick_div3: got %0d exp 4", n); end
    end
    d = $urandom_range(1, 9);
    bus_write(ADDR_DIV, 32'(d));
    wait_pulse(n);
    for (int i = 0; i < 2; i++) begin
      wait_pulse(n);
      checks++; if (n !== d + 1) begin errors++; $display("FAIL tick_divrand: got %0d exp %0d", n, d + 1); end
    end
    bus_write(ADDR_DIV, 32'd0);
    hi = 0;
    repeat (10) begin if (en_rx) hi++; step(); end
    checks++; if (hi !== 10) begin errors++; $display("FAIL tick_div0: got %0d exp 10", hi); end
    bus_write(ADDR_CTRL, 32'd0);
    hi = 0;
    repeat (20) begin if (en_rx) hi++; step(); end
    checks++; if (hi !== 0) begin errors++; $display("FAIL tick_off: got %0d exp 0", hi); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    logic [7:0]  e;
    bus_write(ADDR_CTRL, 32'd2);
    send_byte(8'hA5, 0);
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL single_status: got %h exp %h", d, exp_status()); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b exp 1", bus.irq); end
    e = model_q.pop_front();
    bus_read(ADDR_DATA, d);
    checks++; if (d !== {24'd0, e}) begin errors++; $display("FAIL single_data: got %h exp %h", d, e); end
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL single_empty: got %h exp %h", d, exp_status()); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL single_irq_off: got %b exp 0", bus.irq); end
    bus_read(ADDR_DATA, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL empty_read: got %h exp 0", d); end
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL empty_read_ptr: got %h exp %h", d, exp_status()); end
  endtask

  task automatic test_hold();
    logic [31:0] d;
    logic [7:0]  e;
    send_byte(8'($urandom), 10);
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL hold_status: got %h exp %h", d, exp_status()); end
    e = model_q.pop_front();
    bus_read(ADDR_DATA, d);
    checks++; if (d !== {24'd0, e}) begin errors++; $display("FAIL hold_data: got %h exp %h", d, e); end
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL hold_single_push: got %h exp %h", d, exp_status()); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic [7:0]  e;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL ovr_status: got %h exp %h", d, exp_status()); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL ovr_irq: got %b exp 1", bus.irq); end
    for (int i = 0; i < 4; i++) begin
      e = model_q.pop_front();
      bus_read(ADDR_DATA, d);
      checks++; if (d !== {24'd0, e}) begin errors++; $display("FAIL ovr_data%0d: got %h exp %h", i, d, e); end
    end
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL ovr_sticky: got %h exp %h", d, exp_status()); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL ovr_irq_sticky: got %b exp 1", bus.irq); end
  endtask

  task automatic test_pop_in_capture();
    logic [31:0] d;
    logic [7:0]  e, b;
    bit          seen;
    bus_write(ADDR_STATUS, 32'h8);
    model_ovr = 1'b0;
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL ovr_clear0: got %h exp %h", d, exp_status()); end
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    // rs rises now; 2 sync stages + IDLE put the FSM in CAPTURE after 3 clocks.
    b = 8'($urandom);
    rx_data = b; rx_rs = 1'b1;
    step(3);
    e = model_q.pop_front();
    bus_read(ADDR_DATA, d);
    model_q.push_back(b);
    checks++; if (d !== {24'd0, e}) begin errors++; $display("FAIL cap_pop_data: got %h exp %h", d, e); end
    seen = rx_over_read;
    for (int i = 0; i < 10 && !seen; i++) begin step(); seen = rx_over_read; end
    rx_rs = 1'b0;
    step(6);
    checks++; if (!seen) begin errors++; $display("FAIL cap_over_read: got timeout exp pulse"); end
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL cap_no_ovr: got %h exp %h", d, exp_status()); end
    send_byte(8'($urandom), 0);
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL cap_ovr_set: got %h exp %h", d, exp_status()); end
    bus_write(ADDR_STATUS, 32'h8);
    model_ovr = 1'b0;
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL ovr_clear: got %h exp %h", d, exp_status()); end
    bus_write(ADDR_DATA, 32'hFF);
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL data_wr_ignored: got %h exp %h", d, exp_status()); end
    while (model_q.size() != 0) begin
      e = model_q.pop_front();
      bus_read(ADDR_DATA, d);
      checks++; if (d !== {24'd0, e}) begin errors++; $display("FAIL cap_drain: got %h exp %h", d, e); end
    end
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL cap_drained: got %h exp %h", d, exp_status()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [7:0]  b, e;
    bit          seen;
    send_byte(8'($urandom), 0);
    b = 8'($urandom);
    rx_data = b; rx_rs = 1'b1;
    seen = rx_over_read;
    for (int i = 0; i < 30 && !seen; i++) begin step(); seen = rx_over_read; end
    checks++; if (!seen) begin errors++; $display("FAIL mid_clear_reach: got timeout exp pulse"); end
    rst = 1'b1;
    step(2);
    model_q.delete(); model_ovr = 1'b0;
    checks++; if (rx_over_read !== 1'b0) begin errors++; $display("FAIL mid_over_read: got %b exp 0", rx_over_read); end
    checks++; if (en_rx !== 1'b0) begin errors++; $display("FAIL mid_en_rx: got %b exp 0", en_rx); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b exp 0", bus.irq); end
    peek(ADDR_STATUS, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_status: got %h exp 0", d); end
    peek(ADDR_DIV, d);
    checks++; if (d !== 32'd27) begin errors++; $display("FAIL mid_div: got %h exp 1b", d); end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin step(); seen = rx_over_read; end
    rx_rs = 1'b0;
    step(6);
    checks++; if (!seen) begin errors++; $display("FAIL mid_recapture: got timeout exp pulse"); end
    model_rx(b);
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin errors++; $display("FAIL mid_status2: got %h exp %h", d, exp_status()); end
    e = model_q.pop_front();
    bus_read(ADDR_DATA, d);
    checks++; if (d !== {24'd0, e}) begin errors++; $display("FAIL mid_data: got %h exp %h", d, e); end
  endtask

  initial begin
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
    test_reset();
    test_tick();
    test_single();
    test_hold();
    test_overrun();
    test_pop_in_capture();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
